led_blink_ctrl: RTL and testbench

- Parametrised multi-channel successor to the single-LED blinker.
- Drives NUM_CH LEDs from one shared tick prescaler.
- Each channel has a runtime-programmable mode (off / on / continuous blink / N-period burst), period and on-time.
- Programmed through a valid/ready config port from the board-level control logic; sits directly at the LED pins.

---
 rtl/led_blink_pkg.sv | 18 +
 rtl/blink_channel.sv | 91 +++++++++
 rtl/led_blink_ctrl.sv | 77 +++++++
 tb/tb_led_blink_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared mode encoding and channel-index width helper
package led_blink_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    // Channel-select width: at least one bit even for a single channel
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blink_channel.sv
// blink_channel: per-LED settings, phase counter and burst sequencing
module blink_channel
    import led_blink_pkg::*;
#(
    parameter int PER_W = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic              i_load,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [PER_W-1:0]  i_period,
    input  logic [PER_W-1:0]  i_on,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_led_raw,
    output logic              o_done
);

    mode_e            r_mode, w_mode_n;
    logic [PER_W-1:0] r_per, r_on, r_phase, w_per_n, w_on_n, w_phase_n, w_per_eff;
    logic [CNT_W-1:0] r_cnt, r_bcnt, w_cnt_n, w_bcnt_n;
    logic             w_run, w_wrap, w_led_n, w_done_n;

    assign w_per_eff = (r_per == '0) ? PER_W'(1) : r_per;
    assign w_run     = (r_mode == MODE_BLINK) || (r_mode == MODE_BURST);
    assign w_wrap    = (r_phase == w_per_eff - PER_W'(1));

    // State register: settings, counters and the registered LED/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_OFF;
            r_per     <= '0;
            r_on      <= '0;
            r_cnt     <= '0;
            r_phase   <= '0;
            r_bcnt    <= '0;
            o_led_raw <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            r_mode    <= w_mode_n;
            r_per     <= w_per_n;
            r_on      <= w_on_n;
            r_cnt     <= w_cnt_n;
            r_phase   <= w_phase_n;
            r_bcnt    <= w_bcnt_n;
            o_led_raw <= w_led_n;
            o_done    <= w_done_n;
        end
    end

    // Next state: a load always wins over tick advance and burst completion
    always_comb begin
        w_mode_n  = r_mode;
        w_per_n   = r_per;
        w_on_n    = r_on;
        w_cnt_n   = r_cnt;
        w_phase_n = r_phase;
        w_bcnt_n  = r_bcnt;
        w_done_n  = 1'b0;
        if (i_load) begin
            w_mode_n  = mode_e'(i_mode);
            w_per_n   = i_period;
            w_on_n    = i_on;
            w_cnt_n   = i_count;
            w_phase_n = '0;
            w_bcnt_n  = '0;
            if ((mode_e'(i_mode) == MODE_BURST) && (i_count == '0)) begin
                w_mode_n = MODE_OFF;
                w_done_n = 1'b1;
            end
        end else if (w_run && i_tick) begin
            w_phase_n = w_wrap ? '0 : r_phase + PER_W'(1);
            if ((r_mode == MODE_BURST) && w_wrap) begin
                w_bcnt_n = r_bcnt + CNT_W'(1);
                if (w_bcnt_n == r_cnt) begin
                    w_mode_n  = MODE_OFF;
                    w_phase_n = '0;
                    w_done_n  = 1'b1;
                end
            end
        end
    end

    // Output: LED computed from next state so it changes on the same edge
    always_comb begin
        w_led_n = (w_mode_n == MODE_ON) ||
                  (((w_mode_n == MODE_BLINK) || (w_mode_n == MODE_BURST)) && (w_phase_n < w_on_n));
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED blinker with shared tick prescaler and config port
// Optional LED_ACTIVE_LOW_EN: invert led outputs (reset value all-ones)
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  CLK_DIV = 50000,
    parameter int  PER_W   = 16,
    parameter int  CNT_W   = 8,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PER_W-1:0]  cfg_on,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] done
);

    localparam int PRE_W = $clog2(CLK_DIV);

    logic [PRE_W-1:0]  r_pre;
    logic              w_tick, w_acc, w_bad;
    logic [NUM_CH-1:0] w_led_raw;

    assign w_tick = (r_pre == PRE_W'(CLK_DIV - 1));
    assign w_acc  = cfg_valid && cfg_ready;
    assign w_bad  = ({1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH));

    // Free-running prescaler, untouched by config writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pre <= '0;
        else        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
    end

    // Ready comes up one edge after reset; bad-address writes flag cfg_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= w_acc && w_bad;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        blink_channel #(
            .PER_W (PER_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_load    (w_acc && !w_bad && (cfg_ch == CH_W'(g))),
            .i_mode    (cfg_mode),
            .i_period  (cfg_period),
            .i_on      (cfg_on),
            .i_count   (cfg_count),
            .o_led_raw (w_led_raw[g]),
            .o_done    (done[g])
        );
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~w_led_raw;
`else
    assign led = w_led_raw;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: table, directed and random checks against a tick-count model
module tb_led_blink_ctrl;

    localparam int NUM_CH  = 4;
    localparam int CLK_DIV = 4;
`ifdef LED_ACTIVE_LOW_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk, rst_n;
    logic        cfg_valid, cfg_ready, cfg_err;
    logic [1:0]  cfg_ch, cfg_mode;
    logic [15:0] cfg_period, cfg_on;
    logic [7:0]  cfg_count;
    logic [3:0]  led, done;

    logic        v3, ready3, err3;
    logic [1:0]  ch3;
    logic [2:0]  led3, done3;

    led_blink_ctrl #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PER_W(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
        .cfg_count(cfg_count), .cfg_err(cfg_err), .led(led), .done(done)
    );

    led_blink_ctrl #(.NUM_CH(3), .CLK_DIV(CLK_DIV), .PER_W(16), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v3), .cfg_ready(ready3),
        .cfg_ch(ch3), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
        .cfg_count(cfg_count), .cfg_err(err3), .led(led3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: each channel tracks ticks elapsed since its last load
    int         m_mode[NUM_CH], m_per[NUM_CH], m_on[NUM_CH], m_cnt[NUM_CH], m_ticks[NUM_CH];
    logic [3:0] m_led, m_done;
    bit         m_err, m_ready;
    int         e_cnt;

    typedef struct {
        int ch;
        int mode;
        int per;
        int on;
        int cnt;
        bit exp;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [3:0] pol4(input logic [3:0] v);
        return INV ? ~v : v;
    endfunction

    function automatic logic [2:0] pol3(input logic [2:0] v);
        return INV ? ~v : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 0; m_per[i] = 0; m_on[i] = 0; m_cnt[i] = 0; m_ticks[i] = 0;
        end
        m_led = '0; m_done = '0; m_err = 1'b0; m_ready = 1'b0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit acc, tick;
        int eff;
        acc = cfg_valid && m_ready;
        e_cnt++;
        tick = (e_cnt % CLK_DIV) == 0;
        m_done = '0;
        m_err = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            eff = (m_per[i] == 0) ? 1 : m_per[i];
            if (acc && int'(cfg_ch) == i) begin
                m_mode[i] = int'(cfg_mode); m_per[i] = int'(cfg_period);
                m_on[i] = int'(cfg_on); m_cnt[i] = int'(cfg_count); m_ticks[i] = 0;
                if (m_mode[i] == 3 && m_cnt[i] == 0) begin
                    m_mode[i] = 0; m_done[i] = 1'b1;
                end
            end else if (m_mode[i] >= 2 && tick) begin
                m_ticks[i]++;
                if (m_mode[i] == 3 && m_ticks[i] == m_cnt[i] * eff) begin
                    m_mode[i] = 0; m_done[i] = 1'b1;
                end
            end
            eff = (m_per[i] == 0) ? 1 : m_per[i];
            m_led[i] = (m_mode[i] == 1) || (m_mode[i] >= 2 && (m_ticks[i] % eff) < m_on[i]);
        end
        m_ready = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        chk("led", led, pol4(m_led));
        chk("done", done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("cfg_ready", cfg_ready, m_ready);
    endtask

    task automatic wr(input int ch, input int mode, input int per, input int on, input int cnt);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
        cfg_period = 16'(per); cfg_on = 16'(on); cfg_count = 8'(cnt);
        cycle();
        cfg_valid = 1'b0;
    endtask

    // Make the next edge a tick edge so the following write lands on it
    task automatic align();
        while (((e_cnt + 1) % CLK_DIV) != 0) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, dn, dat;
        tbl[0] = '{1, 2, 4, 0, 0, 1'b0};
        tbl[1] = '{1, 2, 4, 5, 0, 1'b1};
        tbl[2] = '{1, 2, 0, 1, 0, 1'b1};
        tbl[3] = '{1, 2, 0, 0, 0, 1'b0};
        tbl[4] = '{1, 1, 7, 0, 0, 1'b1};
        tbl[5] = '{1, 0, 3, 3, 0, 1'b0};
        tbl[6] = '{3, 3, 0, 1, 200, 1'b1};
        tbl[7] = '{2, 2, 4, 4, 0, 1'b1};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_period = '0; cfg_on = '0; cfg_count = '0; v3 = 1'b0; ch3 = '0;
        model_reset();
        repeat (3) cycle();
        chk("rst_led", led, pol4(4'b0000));
        chk("rst_ready", cfg_ready, 0);
        rst_n = 1'b1;
        cycle();
        chk("ready_up", cfg_ready, 1);

        align();
        wr(0, 2, 4, 1, 0);
        hi = led[0] ^ INV;
        for (int k = 1; k < 64; k++) begin
            cycle();
            hi += led[0] ^ INV;
        end
        chk("blink_high_cycles", hi, 16);
        chk("blink_others", led[3:1] ^ {3{INV}}, 0);

        for (int t = 0; t < 8; t++) begin
            wr(tbl[t].ch, tbl[t].mode, tbl[t].per, tbl[t].on, tbl[t].cnt);
            for (int k = 0; k < 20; k++) begin
                chk($sformatf("tbl%0d_led", t), led[tbl[t].ch] ^ INV, tbl[t].exp);
                cycle();
            end
        end

        align();
        wr(2, 3, 2, 1, 3);
        hi = led[2] ^ INV; dn = 0; dat = -1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            hi += led[2] ^ INV;
            if (done[2]) begin
                dn++;
                if (dat < 0) dat = k;
            end
        end
        chk("burst_high_cycles", hi, 12);
        chk("burst_done_count", dn, 1);
        chk("burst_done_at", dat, 24);
        chk("burst_led_off", led[2] ^ INV, 0);

        wr(1, 3, 3, 1, 0);
        chk("cnt0_done", done[1], 1);
        chk("cnt0_led", led[1] ^ INV, 0);
        cycle();
        chk("cnt0_done_once", done[1], 0);

        align();
        wr(2, 3, 2, 1, 1);
        repeat (7) cycle();
        wr(2, 1, 0, 0, 0);
        chk("coll_led", led[2] ^ INV, 1);
        chk("coll_done", done[2], 0);
        cycle();
        chk("coll_done_next", done[2], 0);

        v3 = 1'b1; ch3 = 2'd0; cfg_mode = 2'd1;
        cycle();
        v3 = 1'b0;
        chk("d3_led_on", led3, pol3(3'b001));
        chk("d3_err_idle", err3, 0);
        v3 = 1'b1; ch3 = 2'd3; cfg_mode = 2'd0;
        cycle();
        v3 = 1'b0;
        chk("d3_err", err3, 1);
        chk("d3_led_keep", led3, pol3(3'b001));
        cycle();
        chk("d3_err_once", err3, 0);
        chk("d3_led_keep2", led3, pol3(3'b001));

        repeat (400) begin
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = 16'($urandom_range(0, 5));
            cfg_on     = 16'($urandom_range(0, 6));
            cfg_count  = 8'($urandom_range(0, 3));
            cycle();
        end
        cfg_valid = 1'b0;

        wr(3, 2, 4, 2, 0);
        chk("mr_high", led[3] ^ INV, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_led", led, pol4(4'b0000));
        chk("mr_done", done, 0);
        chk("mr_ready", cfg_ready, 0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
